// File: rtl/parallel_sorter_pkg.sv
// parallel_sorter_pkg: shared default geometry for the sorter and its rank units
package parallel_sorter_pkg;
  localparam int DW_DEF = 3;
  localparam int N_DEF = 4;
endpackage

// File: rtl/parallel_sorter_rank.sv
// parallel_sorter_rank: output slot of element IDX (smaller count plus lower-index ties)
module parallel_sorter_rank
  import parallel_sorter_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int N = N_DEF,
  parameter int IDX = 0
) (
  input  logic [DW*N-1:0]      bus_i,
  output logic [$clog2(N)-1:0] rank_o
);
  localparam int RW = $clog2(N);
  logic [DW-1:0] a;
  assign a = bus_i[IDX*DW +: DW];
  // count the elements that must sit below element IDX; equal values go lower when their index is lower
  always_comb begin
    rank_o = '0;
    for (int j = 0; j < N; j++)
      rank_o = rank_o + RW'((bus_i[j*DW +: DW] < a) || (j < IDX && bus_i[j*DW +: DW] == a));
  end
endmodule

// File: rtl/parallel_sorter.sv
// parallel_sorter: single-cycle rank-based ascending sort with registered output
module parallel_sorter
  import parallel_sorter_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int N = N_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [DW*N-1:0] inp,
  output logic [DW*N-1:0] outp
);
  localparam int TW = DW * N;
  localparam int RW = $clog2(N);
  logic [RW-1:0] rank [N];
  logic [TW-1:0] outp_d, outp_q;
  genvar g;
  generate
    for (g = 0; g < N; g++) begin : g_rank
      parallel_sorter_rank #(.DW(DW), .N(N), .IDX(g)) u_rank (.bus_i(inp), .rank_o(rank[g]));
    end
  endgenerate
  // ranks are a permutation, so each slot ORs together exactly one selected element
  always_comb begin
    outp_d = '0;
    for (int k = 0; k < N; k++)
      for (int i = 0; i < N; i++)
        outp_d[k*DW +: DW] = outp_d[k*DW +: DW] | (inp[i*DW +: DW] & {DW{rank[i] == RW'(k)}});
  end
  // output register; reset clears it and discards that edge's sample
  always_ff @(posedge clk)
    outp_q <= rst ? '0 : outp_d;
  assign outp = outp_q;
endmodule

// File: tb/tb_parallel_sorter.sv
// tb_parallel_sorter: directed vectors plus a counter sweep against an insertion-sort model
module tb_parallel_sorter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] inp = '0;
  logic [11:0] outp;
  int          vecs = 0;
  int          errs = 0;
  logic [11:0] exp_prev = 'x;

  parallel_sorter dut (.clk(clk), .rst(rst), .inp(inp), .outp(outp));

  always #5 clk = ~clk;

  function automatic logic [11:0] ref_sort(input logic [11:0] v);
    logic [2:0] e [4];
    logic [2:0] t;
    logic [11:0] r;
    for (int i = 0; i < 4; i++) e[i] = v[i*3 +: 3];
    for (int i = 1; i < 4; i++)
      for (int j = i; j > 0 && e[j-1] > e[j]; j--) begin
        t = e[j]; e[j] = e[j-1]; e[j-1] = t;
      end
    r = '0;
    for (int i = 0; i < 4; i++) r[i*3 +: 3] = e[i];
    return r;
  endfunction

  task automatic step(input string tag, input logic [11:0] v, input logic r, input logic [11:0] exp);
    @(negedge clk);
    inp = v;
    rst = r;
    #1;
    if (!$isunknown(exp_prev)) begin
      vecs++;
      assert (outp === exp_prev) else begin
        errs++;
        $error("FAIL %s_hold: outp=%h expected %h", tag, outp, exp_prev);
      end
    end
    @(posedge clk);
    #1;
    vecs++;
    assert (outp === exp) else begin
      errs++;
      $error("FAIL %s: outp=%h expected %h", tag, outp, exp);
    end
    exp_prev = exp;
  endtask

  initial begin
    logic [11:0] c;
    step("reset0", 12'hFFF, 1'b1, 12'h000);
    step("reset1", 12'hFFF, 1'b1, 12'h000);
    step("first", 12'h2AE, 1'b0, 12'hD51);
    step("cnt687", 12'h2AF, 1'b0, 12'hF51);
    c = 12'd688;
    for (int n = 0; n < 24; n++) begin
      if (n == 10) step("midrst", c, 1'b1, 12'h000);
      else step("sweep", c, 1'b0, ref_sort(c));
      c = c + 12'd1;
    end
    step("dups", 12'hE24, 1'b0, 12'hF20);
    step("alleq", 12'h6DB, 1'b0, 12'h6DB);
    step("reverse", 12'h977, 1'b0, 12'hFAC);
    step("sorted", 12'hFAC, 1'b0, 12'hFAC);
    step("allmax", 12'hFFF, 1'b0, 12'hFFF);
    step("zeromax", 12'h1C7, 1'b0, 12'hFC0);
    step("allzero", 12'h000, 1'b0, 12'h000);
    step("rstdom", 12'h977, 1'b1, 12'h000);
    step("resume", 12'h977, 1'b0, 12'hFAC);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
